// File: rtl/vec_pkg.sv
// Shared defaults, types and FSM encoding for the scalar-to-vector write packer.
package vec_pkg;

  localparam int LANES_DEF   = 8;
  localparam int LANE_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 16;
  localparam int LG_LANES    = $clog2(LANES_DEF);

  typedef logic [LANES_DEF-1:0]            lane_mask_t;
  typedef logic [LANES_DEF*LANE_W_DEF-1:0] vec_line_t;

  // IDLE: line buffer empty; FILL: line buffer holds at least one lane.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_e;

  // Width of a counter that must reach t; a zero timeout still needs one bit.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/vec_line_buf.sv
// Lane buffer for one vector line: lane write, mask merge, full detect and
// zeroing of lanes that were never written.
module vec_line_buf
  import vec_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int LGL    = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,    // commit the merged line
  input  logic                      clr_i,     // empty the buffer
  input  logic                      fresh_i,   // merge onto an empty line
  input  logic [LGL-1:0]            lane_i,
  input  logic [LANE_W-1:0]         wr_data_i,
  output logic [LANES*LANE_W-1:0]   cur_data_o,
  output logic [LANES-1:0]          cur_mask_o,
  output logic [LANES*LANE_W-1:0]   mrg_data_o,
  output logic [LANES-1:0]          mrg_mask_o,
  output logic                      mrg_full_o
);

  logic [LANES*LANE_W-1:0] data_q;
  logic [LANES-1:0]        mask_q;
  logic [LANES*LANE_W-1:0] raw_d;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic hit;
      assign hit = (lane_i == LGL'(gi));
      // A fresh line starts from nothing, so stale lanes never leak forward.
      assign mrg_mask_o[gi] = hit | (!fresh_i & mask_q[gi]);
      assign raw_d[gi*LANE_W +: LANE_W] =
        hit ? wr_data_i : (fresh_i ? '0 : data_q[gi*LANE_W +: LANE_W]);
      assign mrg_data_o[gi*LANE_W +: LANE_W] =
        mrg_mask_o[gi] ? raw_d[gi*LANE_W +: LANE_W] : '0;
      assign cur_data_o[gi*LANE_W +: LANE_W] =
        mask_q[gi] ? data_q[gi*LANE_W +: LANE_W] : '0;
    end
  endgenerate

  assign cur_mask_o = mask_q;
  assign mrg_full_o = &mrg_mask_o;

  // Buffer register: clear wins over load so a completed line leaves it empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      mask_q <= '0;
    end else if (load_i) begin
      data_q <= mrg_data_o;
      mask_q <= mrg_mask_o;
    end
  end

endmodule

// File: rtl/vec_pack_unit.sv
// Scalar-to-vector write packer: gathers scalar stores to one line and emits a
// masked vector write on full line, line switch, flush or idle timeout.
module vec_pack_unit
  import vec_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int LANE_W  = LANE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [ADDR_W-1:0]                 s_addr,
  input  logic [LANE_W-1:0]                 s_data,
  input  logic                              flush,
  output logic                              v_valid,
  input  logic                              v_ready,
  output logic [ADDR_W-$clog2(LANES)-1:0]   v_addr,
  output logic [LANES*LANE_W-1:0]           v_data,
  output logic [LANES-1:0]                  v_mask,
  output logic                              busy
);

  localparam int LGL   = $clog2(LANES);
  localparam int VA_W  = ADDR_W - LGL;
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  pack_state_e             state_q, state_d;
  logic [VA_W-1:0]         line_q, line_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    v_valid_q, v_valid_d;
  logic [VA_W-1:0]         v_addr_q, v_addr_d;
  logic [LANES*LANE_W-1:0] v_data_q, v_data_d;
  logic [LANES-1:0]        v_mask_q, v_mask_d;

  logic [VA_W-1:0]         s_line;
  logic [LGL-1:0]          s_lane;
  logic                    out_free, accept, same_line, to_hit;
  logic                    complete, switch_emit, drain, emit;
  logic [LANES*LANE_W-1:0] cur_data, mrg_data;
  logic [LANES-1:0]        cur_mask, mrg_mask;
  logic                    mrg_full;

  assign s_line    = s_addr[ADDR_W-1:LGL];
  assign s_lane    = s_addr[LGL-1:0];
  assign out_free  = !v_valid_q || v_ready;
  assign s_ready   = out_free && !flush;
  assign accept    = s_valid && s_ready;
  assign same_line = (state_q == FILL) && (s_line == line_q);
  assign to_hit    = (TIMEOUT != 0) && (cnt_q == TO_VAL);

  // Emission causes are mutually exclusive: accept needs !flush, drain needs !accept.
  assign complete    = accept && mrg_full;
  assign switch_emit = accept && (state_q == FILL) && !same_line;
  assign drain       = (state_q == FILL) && !accept && out_free && (flush || to_hit);
  assign emit        = complete || switch_emit || drain;

  vec_line_buf #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept && !complete),
    .clr_i      (complete || drain),
    .fresh_i    (!same_line),
    .lane_i     (s_lane),
    .wr_data_i  (s_data),
    .cur_data_o (cur_data),
    .cur_mask_o (cur_mask),
    .mrg_data_o (mrg_data),
    .mrg_mask_o (mrg_mask),
    .mrg_full_o (mrg_full)
  );

  // Next-state, line tag and idle counter.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FILL;
          line_d  = s_line;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (complete || drain) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = '0;
          if (!same_line) line_d = s_line;
        end else if (cnt_q != TO_VAL) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot: load on emission, otherwise empty on handshake; payload holds.
  always_comb begin
    v_valid_d = v_valid_q;
    v_addr_d  = v_addr_q;
    v_data_d  = v_data_q;
    v_mask_d  = v_mask_q;
    if (emit) begin
      v_valid_d = 1'b1;
      v_addr_d  = line_q;
      v_data_d  = complete ? mrg_data : cur_data;
      v_mask_d  = complete ? mrg_mask : cur_mask;
    end else if (v_ready) begin
      v_valid_d = 1'b0;
    end
  end

  // State, counter and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      line_q    <= '0;
      cnt_q     <= '0;
      v_valid_q <= 1'b0;
      v_addr_q  <= '0;
      v_data_q  <= '0;
      v_mask_q  <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      v_valid_q <= v_valid_d;
      v_addr_q  <= v_addr_d;
      v_data_q  <= v_data_d;
      v_mask_q  <= v_mask_d;
    end
  end

  assign v_valid = v_valid_q;
  assign v_addr  = v_addr_q;
  assign v_data  = v_data_q;
  assign v_mask  = v_mask_q;
  assign busy    = (state_q == FILL) || v_valid_q;

endmodule

// File: tb/tb_vec_pack_unit.sv
// Directed and randomized checks of vec_pack_unit against a line-level model.
module tb_vec_pack_unit;
  import vec_pkg::*;

  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int ADDR_W = 16;
  localparam int TO     = 4;
  localparam int VW     = LANES * LANE_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              s_valid, s_ready, flush, v_valid, v_ready, busy;
  logic [ADDR_W-1:0] s_addr;
  logic [LANE_W-1:0] s_data;
  logic [12:0]       v_addr;
  logic [VW-1:0]     v_data;
  logic [LANES-1:0]  v_mask;

  logic              s_valid0, s_ready0, flush0, v_valid0, v_ready0, busy0;
  logic [ADDR_W-1:0] s_addr0;
  logic [LANE_W-1:0] s_data0;
  logic [12:0]       v_addr0;
  logic [VW-1:0]     v_data0;
  logic [LANES-1:0]  v_mask0;

  vec_pack_unit #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_data(s_data), .flush(flush), .v_valid(v_valid), .v_ready(v_ready),
    .v_addr(v_addr), .v_data(v_data), .v_mask(v_mask), .busy(busy));

  vec_pack_unit #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid0), .s_ready(s_ready0), .s_addr(s_addr0),
    .s_data(s_data0), .flush(flush0), .v_valid(v_valid0), .v_ready(v_ready0),
    .v_addr(v_addr0), .v_data(v_data0), .v_mask(v_mask0), .busy(busy0));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input vec_line_t obs, input vec_line_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a line of lanes plus a one-entry pending write.
  bit              m_active;
  int unsigned     m_line;
  logic [31:0]     m_data [LANES];
  bit [LANES-1:0]  m_mask;
  int              m_idle;
  bit              m_vv;
  int unsigned     m_va;
  vec_line_t       m_vd;
  bit [LANES-1:0]  m_vm;

  task automatic model_clear();
    m_active = 0;
    m_mask   = '0;
    m_idle   = 0;
    for (int i = 0; i < LANES; i++) m_data[i] = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_line = 0;
    m_vv = 0; m_va = 0; m_vd = '0; m_vm = '0;
  endtask

  task automatic model_emit();
    m_vv = 1;
    m_va = m_line;
    m_vm = m_mask;
    m_vd = '0;
    for (int i = 0; i < LANES; i++)
      if (m_mask[i]) m_vd[i*LANE_W +: LANE_W] = m_data[i];
  endtask

  task automatic model_step();
    bit free, acc;
    int unsigned ln;
    int lane;
    if (!rst_n) begin
      model_reset();
      return;
    end
    free = !m_vv || v_ready;
    acc  = s_valid && free && !flush;
    ln   = int'(s_addr) / LANES;
    lane = int'(s_addr) % LANES;
    if (m_vv && v_ready) m_vv = 0;
    if (acc) begin
      if (m_active && ln == m_line) begin
        m_data[lane] = s_data;
        m_mask[lane] = 1'b1;
        m_idle = 0;
        if (&m_mask) begin
          model_emit();
          model_clear();
        end
      end else begin
        if (m_active) model_emit();
        model_clear();
        m_active = 1;
        m_line = ln;
        m_data[lane] = s_data;
        m_mask[lane] = 1'b1;
      end
    end else if (m_active) begin
      if (free && (flush || (TO != 0 && m_idle == TO))) begin
        model_emit();
        model_clear();
      end else if (m_idle < TO) begin
        m_idle++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Waits up to 10 cycles for v_valid; returns the cycle index or -1.
  task automatic wait_vvalid(output int k);
    k = -1;
    for (int j = 0; j < 10 && k < 0; j++) begin
      cyc();
      @(negedge clk);
      if (v_valid) k = j;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_vvalid"}, v_valid, 0);
    chk({tag, "_vaddr"},  v_addr,  0);
    chk({tag, "_vdata"},  v_data,  0);
    chk({tag, "_vmask"},  v_mask,  0);
    chk({tag, "_busy"},   busy,    0);
  endtask

  vec_line_t   exp_d;
  int          k, cnt;
  logic [15:0] addr_tab [3];
  logic [31:0] data_tab [3];

  initial begin
    rst_n = 0; s_valid = 0; s_addr = '0; s_data = '0; flush = 0; v_ready = 1;
    s_valid0 = 0; s_addr0 = '0; s_data0 = '0; flush0 = 0; v_ready0 = 1;
    model_reset();
    @(negedge clk);
    chk_zero_outputs("reset");
    cyc();
    rst_n = 1;
    @(negedge clk);
    chk("reset_sready", s_ready, 1);

    // Full line 0x40..0x47.
    for (int i = 0; i < 8; i++) begin
      cyc();
      s_valid = 1; s_addr = 16'h40 + 16'(i); s_data = 32'hA0 + 32'(i);
      @(negedge clk);
      chk("full_sready", s_ready, 1);
      chk("full_novalid", v_valid, 0);
    end
    cyc();
    s_valid = 0;
    @(negedge clk);
    exp_d = '0;
    for (int i = 0; i < 8; i++) exp_d[i*32 +: 32] = 32'hA0 + 32'(i);
    chk("full_vvalid", v_valid, 1);
    chk("full_vaddr", v_addr, 13'h08);
    chk("full_vmask", v_mask, 8'hFF);
    chk("full_vdata", v_data, exp_d);
    chk("full_busy", busy, 1);
    cyc();
    @(negedge clk);
    chk("full_vvalid_drop", v_valid, 0);
    chk("full_busy_drop", busy, 0);

    // Line switch, then the remaining partial line drains by timeout.
    addr_tab = '{16'h10, 16'h11, 16'h20};
    data_tab = '{32'h1, 32'h2, 32'h3};
    for (int i = 0; i < 3; i++) begin
      cyc();
      s_valid = 1; s_addr = addr_tab[i]; s_data = data_tab[i];
    end
    cyc();
    s_valid = 0;
    @(negedge clk);
    chk("switch_vvalid", v_valid, 1);
    chk("switch_vaddr", v_addr, 13'h02);
    chk("switch_vmask", v_mask, 8'h03);
    chk("switch_vdata", v_data, {192'h0, 32'h2, 32'h1});
    chk("switch_busy", busy, 1);
    wait_vvalid(k);
    chk("switch_to_latency", 256'(k), 4);
    chk("switch_to_vaddr", v_addr, 13'h04);
    chk("switch_to_vmask", v_mask, 8'h01);
    chk("switch_to_vdata", v_data, 256'h3);
    cyc();

    // Timeout of a single store at 0x33.
    cyc();
    s_valid = 1; s_addr = 16'h33; s_data = 32'h5A;
    cyc();
    s_valid = 0;
    wait_vvalid(k);
    chk("to_latency", 256'(k), 4);
    chk("to_vaddr", v_addr, 13'h06);
    chk("to_vmask", v_mask, 8'h08);
    chk("to_vdata", v_data, 256'h5A << 96);
    cyc();

    // Backpressure: full line with v_ready low, extra store held off.
    v_ready = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      s_valid = 1; s_addr = 16'h60 + 16'(i); s_data = 32'h100 + 32'(i);
    end
    cyc();
    s_addr = 16'h70; s_data = 32'h77;
    exp_d = '0;
    for (int i = 0; i < 8; i++) exp_d[i*32 +: 32] = 32'h100 + 32'(i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sready", s_ready, 0);
      chk("bp_vvalid", v_valid, 1);
      chk("bp_vaddr", v_addr, 13'h0C);
      chk("bp_vdata", v_data, exp_d);
      cyc();
    end
    v_ready = 1;
    @(negedge clk);
    chk("bp_sready_release", s_ready, 1);
    cyc();
    s_valid = 0;
    @(negedge clk);
    chk("bp_vvalid_drop", v_valid, 0);
    chk("bp_busy_held", busy, 1);
    cyc();
    flush = 1;
    cyc();
    flush = 0;
    @(negedge clk);
    chk("bp_flush_vvalid", v_valid, 1);
    chk("bp_flush_vaddr", v_addr, 13'h0E);
    chk("bp_flush_vmask", v_mask, 8'h01);
    chk("bp_flush_vdata", v_data, 256'h77);

    // Overwrite a lane, then flush.
    cyc();
    s_valid = 1; s_addr = 16'h50; s_data = 32'h11;
    cyc();
    s_data = 32'h22;
    cyc();
    s_valid = 0; flush = 1;
    @(negedge clk);
    chk("ow_sready_flush", s_ready, 0);
    cyc();
    @(negedge clk);
    chk("ow_vvalid", v_valid, 1);
    chk("ow_vaddr", v_addr, 13'h0A);
    chk("ow_vmask", v_mask, 8'h01);
    chk("ow_vdata", v_data, 256'h22);
    chk("ow_sready_hold", s_ready, 0);
    cyc();
    flush = 0;
    @(negedge clk);
    chk("ow_sready_back", s_ready, 1);
    chk("ow_vvalid_drop", v_valid, 0);

    // TIMEOUT=0 instance never drains on its own.
    cyc();
    s_valid0 = 1; s_addr0 = 16'h33; s_data0 = 32'h1;
    cyc();
    s_valid0 = 0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (v_valid0) cnt++;
      cyc();
    end
    chk("to0_no_emit", 256'(cnt), 0);
    chk("to0_busy", busy0, 1);

    // Reset in the middle of a line discards it.
    for (int i = 0; i < 3; i++) begin
      cyc();
      s_valid = 1; s_addr = 16'h80 + 16'(i); s_data = 32'hC0 + 32'(i);
    end
    cyc();
    s_valid = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    chk_zero_outputs("midrst");
    cyc();
    rst_n = 1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (v_valid) cnt++;
      cyc();
    end
    chk("midrst_no_emit", 256'(cnt), 0);
    chk("midrst_busy", busy, 0);

    // Randomized traffic over three neighbouring lines versus the model.
    for (int n = 0; n < 800; n++) begin
      cyc();
      s_valid = ($urandom_range(0, 9) < (((n / 100) % 2) ? 3 : 7));
      s_addr  = 16'h0100 + 16'($urandom_range(0, 23));
      s_data  = $urandom;
      v_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      chk("rnd_sready", s_ready, (!m_vv || v_ready) && !flush);
      chk("rnd_vvalid", v_valid, m_vv);
      chk("rnd_busy", busy, m_active || m_vv);
      if (m_vv) begin
        chk("rnd_vaddr", v_addr, 256'(m_va));
        chk("rnd_vmask", v_mask, m_vm);
        chk("rnd_vdata", v_data, m_vd);
      end
    end
    cyc();
    s_valid = 0; flush = 0; v_ready = 1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_pack_unit.md
Name: vec_pack_unit

Overview:
Parametrised scalar-to-vector write packer for the memory stage of the SIMD pipeline. It collects scalar stores aimed at one vector line into a lane buffer. It emits a single masked vector write toward vector RAM when one of these happens: the line is full, a store hits a different line, flush is raised, or an idle timeout expires. It generalises the fixed 8x32 scalar-to-vector copy path with configurable lanes, lane masks, ready/valid backpressure and time-based draining.

Parameters:
LANES, 8, lanes per vector line (power of two, >=2)
LANE_W, 32, bits per lane
ADDR_W, 16, scalar word-address width
TIMEOUT, 16, idle cycles before auto-emit of a partial line; 0 disables

Ports:
clk  in  1  clock; all flops rise-edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  scalar store offered
s_ready  out  1  store accepted this cycle when s_valid&&s_ready
s_addr  in  ADDR_W  scalar word address
s_data  in  LANE_W  scalar store data
flush  in  1  level; drain buffer, block new stores while high
v_valid  out  1  vector write pending
v_ready  in  1  vector RAM consumes the write
v_addr  out  ADDR_W-log2(LANES)  vector line address
v_data  out  LANES*LANE_W  line data; lane i = bits [i*LANE_W +: LANE_W]
v_mask  out  LANES  lane write-enables
busy  out  1  buffer active or v_valid

Behaviour:
- Address split: line = s_addr >> log2(LANES); lane = s_addr[log2(LANES)-1:0].
- Line buffer: line_q, data_q, mask_q, active (FSM: IDLE = empty, FILL = active).
- Output register is a one-entry slot: v_valid, v_addr, v_data, v_mask.
- Slot free this cycle: out_free = !v_valid || v_ready.
- s_ready = out_free && !flush (combinational).
- Accept, state IDLE: load line_q, write the lane, mask_q = onehot(lane), go to FILL.
- Accept, FILL, same line: write the lane and set its mask bit. A re-write of a lane already set overwrites it (last write wins).
- If the resulting mask is all ones: move the line to the slot at the same edge, clear the buffer, go to IDLE.
- Accept, FILL, different line: move the old buffer to the slot, load the new store as a fresh line, stay in FILL.
- Flush: in FILL with out_free, move the buffer to the slot and go to IDLE. In IDLE it has no effect.
- Timeout: idle_cnt clears on every accept and on entry to FILL. It increments each FILL cycle with no accept, saturating at TIMEOUT.
- When idle_cnt == TIMEOUT and out_free: emit the buffer, go to IDLE. If the slot is busy, the emit is held until it is free.
- At most one emission per cycle. The cases above are mutually exclusive because s_ready requires !flush and timeout requires no accept.
- Slot rules: v_valid rises at the edge of an emission. It falls on v_valid&&v_ready unless a new emission loads at the same edge (back-to-back allowed). The payload is stable while v_valid&&!v_ready.
- Unmasked lanes of v_data drive 0.
- Latency: the store that completes a line at edge N gives v_valid=1 in cycle N+1.
- Reset (async, any time, including mid-line): v_valid=0, v_addr=0, v_data=0, v_mask=0, buffer cleared, idle_cnt=0, FSM=IDLE, busy=0. Partial lines are discarded.
- s_ready shows 1 once rst_n is high and flush is low.

Decomposition:
- vec_pkg holds lane-count/width defaults, LG_LANES = $clog2(LANES), typedef lane_mask_t, typedef vec_line_t, and the FSM enum {IDLE, FILL}.
- One sub-module, vec_line_buf, contains the lane write and mask merge, the all-ones detect and the zeroing of unmasked lanes.
- vec_pack_unit keeps the FSM, timeout counter and output slot.

Test Plan:
- Full line: 8 stores at 0x40..0x47, data 0xA0..0xA7, v_ready=1 -> one write, v_addr=0x08, v_mask=0xFF, lane i = 0xA0+i, v_valid high exactly one cycle after the 8th accept.
- Line switch: stores 0x10=0x1, 0x11=0x2, then 0x20=0x3 -> write v_addr=0x02, v_mask=0x03; buffer holds line 0x04 with mask 0x01 and busy=1.
- Backpressure: slot full, v_ready=0 -> s_ready=0 and payload stable for 5 cycles. On v_ready=1 the slot clears and s_ready returns to 1 the same cycle.
- Timeout: TIMEOUT=4, single store at 0x33 -> after 4 idle cycles v_addr=0x06, v_mask=0x08. With TIMEOUT=0 no emit occurs after 100 cycles.
- Overwrite + flush: 0x50=0x11, 0x50=0x22, flush=1 -> v_mask=0x01, lane0=0x22; s_ready=0 while flush is high.
- Reset mid-line: 3 stores, then rst_n low for 1 cycle -> all outputs 0, busy=0, no later emission of the discarded lanes.
